// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM states,
// exception/interrupt cause codes and the trap vector address helper.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRAP     = 2'd1,
        ST_MRET     = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_e;

    // Synchronous exception cause codes (mcause with interrupt bit clear)
    localparam logic [3:0] EXC_INSTR_MISALIGNED   = 4'd0;
    localparam logic [3:0] EXC_INSTR_ACCESS_FAULT = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL_INSTR      = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT         = 4'd3;
    localparam logic [3:0] EXC_LOAD_MISALIGNED    = 4'd4;
    localparam logic [3:0] EXC_LOAD_ACCESS_FAULT  = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGNED   = 4'd6;
    localparam logic [3:0] EXC_STORE_ACCESS_FAULT = 4'd7;
    localparam logic [3:0] EXC_ECALL_U            = 4'd8;
    localparam logic [3:0] EXC_ECALL_M            = 4'd11;

    // Machine interrupt cause codes (mcause with interrupt bit set)
    localparam logic [30:0] IRQ_CODE_MSI = 31'd3;
    localparam logic [30:0] IRQ_CODE_MTI = 31'd7;
    localparam logic [30:0] IRQ_CODE_MEI = 31'd11;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;
    localparam logic [1:0] PRIV_MACHINE        = 2'b11;

    // Handler address: vectored mode only offsets interrupts, and the
    // reserved mode encodings fall back to direct mode.
    function automatic logic [31:0] trapVector(
        input logic [29:0] base,
        input logic [1:0]  mode,
        input logic        isInterrupt,
        input logic [30:0] code
    );
        logic [31:0] addr;
        addr = {base, 2'b00};
        if ((mode == MTVEC_MODE_VECTORED) && isInterrupt) begin
            addr = addr + (32'(code) << 2);
        end
        return addr;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous interrupt level.
module irq_sync #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_chain;

    // Shift the raw level through DEPTH flops; stage 0 may go metastable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[DEPTH-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: samples interrupt lines, keeps the mip
// copies, arbitrates traps/mret at commit and sequences flush + redirect.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int          SYNC_STAGES  = 2,
    parameter logic [31:0] RESET_VECTOR = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_commit_valid,
    input  logic [31:0] i_commit_pc,
    input  logic        i_exc_valid,
    input  logic [3:0]  i_exc_code,
    input  logic [31:0] i_exc_tval,
    input  logic        i_mret_valid,
    input  logic        i_ext_irq,
    input  logic        i_timer_irq,
    input  logic        i_sw_irq,
    input  logic        i_mstatus_mie,
    input  logic        i_mstatus_mpie,
    input  logic [29:0] i_mtvec_base,
    input  logic [1:0]  i_mtvec_mode,
    input  logic [31:0] i_mepc,
    input  logic        i_mie_msie,
    input  logic        i_mie_mtie,
    input  logic        i_mie_meie,
    output logic        o_trap_take,
    output logic        o_mret_take,
    output logic        o_mcause_interrupt,
    output logic [30:0] o_mcause_exception_code,
    output logic [31:0] o_mepc_value,
    output logic [31:0] o_mtval_value,
    output logic        o_mstatus_mie,
    output logic        o_mstatus_mpie,
    output logic [1:0]  o_mstatus_mpp,
    output logic        o_mip_msip_wen,
    output logic        o_mip_msip,
    output logic        o_mip_mtip_wen,
    output logic        o_mip_mtip,
    output logic        o_mip_meip_wen,
    output logic        o_mip_meip,
    output logic        o_flush,
    output logic        o_pc_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_busy
);

    logic        w_extSync;
    logic        r_timerSync;
    logic        r_swSync;
    logic        r_mipMeip;
    logic        r_mipMtip;
    logic        r_mipMsip;
    logic        r_meipWen;
    logic        r_mtipWen;
    logic        r_msipWen;
    logic        w_meiReq;
    logic        w_msiReq;
    logic        w_mtiReq;
    logic        w_irqPending;
    logic [30:0] w_irqCode;
    logic        w_commitIdle;
    logic [31:0] w_target;

    trap_state_e r_state;
    trap_state_e w_nextState;

    logic        r_causeInt;
    logic [30:0] r_causeCode;
    logic [31:0] r_mepc;
    logic [31:0] r_mtval;
    logic        r_fromMret;
    logic [31:0] r_redirectPc;

    irq_sync #(
        .DEPTH (SYNC_STAGES)
    ) u_extSync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_ext_irq),
        .o_q   (w_extSync)
    );

    // Timer and software lines are already in this clock domain; one flop aligns them.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_timerSync <= 1'b0;
            r_swSync    <= 1'b0;
        end else begin
            r_timerSync <= i_timer_irq;
            r_swSync    <= i_sw_irq;
        end
    end

    // Track the mip copies and raise a one-cycle write strobe on every level change, in any FSM state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mipMeip <= 1'b0;
            r_mipMtip <= 1'b0;
            r_mipMsip <= 1'b0;
            r_meipWen <= 1'b0;
            r_mtipWen <= 1'b0;
            r_msipWen <= 1'b0;
        end else begin
            r_meipWen <= (w_extSync   != r_mipMeip);
            r_mtipWen <= (r_timerSync != r_mipMtip);
            r_msipWen <= (r_swSync    != r_mipMsip);
            r_mipMeip <= w_extSync;
            r_mipMtip <= r_timerSync;
            r_mipMsip <= r_swSync;
        end
    end

    assign o_mip_meip_wen = r_meipWen;
    assign o_mip_mtip_wen = r_mtipWen;
    assign o_mip_msip_wen = r_msipWen;
    assign o_mip_meip     = r_mipMeip;
    assign o_mip_mtip     = r_mipMtip;
    assign o_mip_msip     = r_mipMsip;

    // Interrupt arbitration on the registered mip copies: MEI beats MSI beats MTI.
    always_comb begin
        w_meiReq     = r_mipMeip & i_mie_meie;
        w_msiReq     = r_mipMsip & i_mie_msie;
        w_mtiReq     = r_mipMtip & i_mie_mtie;
        w_irqPending = i_mstatus_mie & (w_meiReq | w_msiReq | w_mtiReq);
        if (w_meiReq) begin
            w_irqCode = IRQ_CODE_MEI;
        end else if (w_msiReq) begin
            w_irqCode = IRQ_CODE_MSI;
        end else begin
            w_irqCode = IRQ_CODE_MTI;
        end
    end

    assign w_commitIdle = (r_state == ST_IDLE) && i_commit_valid;

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Capture the trap cause at commit; interrupts take precedence over the instruction's own event.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_causeInt  <= 1'b0;
            r_causeCode <= '0;
            r_mepc      <= '0;
            r_mtval     <= '0;
            r_fromMret  <= 1'b0;
        end else if (w_commitIdle) begin
            if (w_irqPending) begin
                r_causeInt  <= 1'b1;
                r_causeCode <= w_irqCode;
                r_mepc      <= i_commit_pc;
                r_mtval     <= '0;
                r_fromMret  <= 1'b0;
            end else if (i_exc_valid) begin
                r_causeInt  <= 1'b0;
                r_causeCode <= {27'd0, i_exc_code};
                r_mepc      <= i_commit_pc;
                r_mtval     <= i_exc_tval;
                r_fromMret  <= 1'b0;
            end else if (i_mret_valid) begin
                r_fromMret  <= 1'b1;
            end
        end
    end

    assign o_mcause_interrupt      = r_causeInt;
    assign o_mcause_exception_code = r_causeCode;
    assign o_mepc_value            = r_mepc;
    assign o_mtval_value           = r_mtval;

    // mret returns to the live mepc; a trap goes to the handler for the latched cause.
    assign w_target = r_fromMret ? i_mepc
                                 : trapVector(i_mtvec_base, i_mtvec_mode, r_causeInt, r_causeCode);

    // Keep the last redirect target visible after REDIRECT so the port never glitches back.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_redirectPc <= RESET_VECTOR;
        end else if (r_state == ST_REDIRECT) begin
            r_redirectPc <= w_target;
        end
    end

    // Next-state logic and per-state pulses; TRAP/MRET/REDIRECT each last exactly one cycle.
    always_comb begin
        w_nextState    = r_state;
        o_trap_take    = 1'b0;
        o_mret_take    = 1'b0;
        o_flush        = 1'b0;
        o_pc_redirect  = 1'b0;
        o_mstatus_mie  = 1'b0;
        o_mstatus_mpie = 1'b0;
        o_mstatus_mpp  = 2'b00;
        o_redirect_pc  = r_redirectPc;
        o_busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (i_commit_valid) begin
                    if (w_irqPending || i_exc_valid) begin
                        w_nextState = ST_TRAP;
                    end else if (i_mret_valid) begin
                        w_nextState = ST_MRET;
                    end
                end
            end
            ST_TRAP: begin
                o_trap_take    = 1'b1;
                o_flush        = 1'b1;
                o_mstatus_mie  = 1'b0;
                o_mstatus_mpie = i_mstatus_mie;
                o_mstatus_mpp  = PRIV_MACHINE;
                w_nextState    = ST_REDIRECT;
            end
            ST_MRET: begin
                o_mret_take    = 1'b1;
                o_flush        = 1'b1;
                o_mstatus_mie  = i_mstatus_mpie;
                o_mstatus_mpie = 1'b1;
                o_mstatus_mpp  = PRIV_MACHINE;
                w_nextState    = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                o_pc_redirect = 1'b1;
                o_redirect_pc = w_target;
                w_nextState   = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

endmodule
